// File: rtl/fetch_buffer_pkg.sv
// Shared types, constants and PC slicing helpers for the instruction fetch buffer.
package fetch_buffer_pkg;

    localparam int VADDR_BITS  = 39;
    localparam int FETCH_WIDTH = 4;
    localparam int INST_BYTES  = 4;
    localparam int INST_BITS   = INST_BYTES * 8;
    localparam int PKT_BITS    = FETCH_WIDTH * INST_BITS;
    localparam int OFF_W       = $clog2(FETCH_WIDTH);
    localparam int OFF_LSB     = $clog2(INST_BYTES);
    localparam int LINE_LSB    = OFF_LSB + OFF_W;
    localparam int NENQ_W      = OFF_W + 1;

    typedef struct packed {
        logic [PKT_BITS-1:0]   data;
        logic [VADDR_BITS-1:0] pc;
    } FetchPacketST;

    typedef struct packed {
        logic [INST_BITS-1:0]  inst;
        logic [VADDR_BITS-1:0] pc;
    } FetchInstST;

    // Index of the first valid instruction slot inside the fetch packet.
    function automatic logic [OFF_W-1:0] pc_slot_off(input logic [VADDR_BITS-1:0] pc);
        return pc[LINE_LSB-1:OFF_LSB];
    endfunction

    // Packet-aligned portion of the PC, shared by every slot of the packet.
    function automatic logic [VADDR_BITS-LINE_LSB-1:0] pc_line(input logic [VADDR_BITS-1:0] pc);
        return pc[VADDR_BITS-1:LINE_LSB];
    endfunction

    // PC of slot k within the packet addressed by pc.
    function automatic logic [VADDR_BITS-1:0] slot_pc(input logic [VADDR_BITS-1:0] pc,
                                                      input logic [OFF_W-1:0]      k);
        return {pc_line(pc), k, {OFF_LSB{1'b0}}};
    endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Enqueue / dequeue / flush bundle between the fetch unit, the buffer and decode.
interface fetch_buffer_if #(
    parameter int NUM_ENTRIES = 16,
    parameter int DEQ_WIDTH   = 2
);
    import fetch_buffer_pkg::*;

    logic                            enq_valid;
    logic                            enq_ready;
    logic [PKT_BITS-1:0]             enq_data;
    logic [VADDR_BITS-1:0]           enq_pc;
    logic [DEQ_WIDTH-1:0]            deq_valid;
    logic [DEQ_WIDTH*INST_BITS-1:0]  deq_inst;
    logic [DEQ_WIDTH*VADDR_BITS-1:0] deq_pc;
    logic                            deq_ready;
    logic                            flush;
    logic [$clog2(NUM_ENTRIES):0]    count;

    // Fetch / decode side driving the buffer.
    modport master (
        output enq_valid, enq_data, enq_pc, deq_ready, flush,
        input  enq_ready, deq_valid, deq_inst, deq_pc, count
    );

    // The buffer itself.
    modport slave (
        input  enq_valid, enq_data, enq_pc, deq_ready, flush,
        output enq_ready, deq_valid, deq_inst, deq_pc, count
    );

endinterface

// File: rtl/fetch_buffer_expand.sv
// Splits one fetch packet into per-slot instruction/PC pairs and marks the live slots.
module fetch_packet_expand
    import fetch_buffer_pkg::*;
(
    input  FetchPacketST           i_pkt,
    output logic [FETCH_WIDTH-1:0] o_slot_valid,
    output FetchInstST             o_slot [FETCH_WIDTH],
    output logic [NENQ_W-1:0]      o_nenq
);

    logic [OFF_W-1:0] w_off;

    assign w_off = pc_slot_off(i_pkt.pc);

    // Slot k carries word k; slots below the PC offset precede the fetch target and are dropped.
    always_comb begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            o_slot_valid[k] = (k >= int'(w_off));
            o_slot[k].inst  = i_pkt.data[k*INST_BITS +: INST_BITS];
            o_slot[k].pc    = slot_pc(i_pkt.pc, OFF_W'(k));
        end
        o_nenq = NENQ_W'(FETCH_WIDTH) - NENQ_W'(w_off);
    end

endmodule

// File: rtl/fetch_buffer.sv
// Circular instruction queue between the I-cache response and decode.
// Full packets are accepted only with room for FETCH_WIDTH slots; up to
// DEQ_WIDTH in-order instructions are offered per cycle; flush empties it.
module fetch_buffer #(
    parameter int NUM_ENTRIES = 16,
    parameter int DEQ_WIDTH   = 2
) (
    input logic          clock,
    input logic          reset,
    fetch_buffer_if.slave io
);
    import fetch_buffer_pkg::*;

    localparam int PTR_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = PTR_W + 1;

    FetchInstST             r_mem [NUM_ENTRIES];
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [CNT_W-1:0]       r_count;

    FetchPacketST           w_pkt;
    logic [FETCH_WIDTH-1:0] w_slot_valid;
    FetchInstST             w_slot [FETCH_WIDTH];
    logic [NENQ_W-1:0]      w_nenq;
    logic [OFF_W-1:0]       w_off;
    logic [PTR_W-1:0]       w_wr_idx [FETCH_WIDTH];
    logic                   w_enq_ready;
    logic                   w_enq_fire;
    logic                   w_deq_fire;
    logic [CNT_W-1:0]       w_ndeq;

    assign w_pkt.data = io.enq_data;
    assign w_pkt.pc   = io.enq_pc;
    assign w_off      = pc_slot_off(io.enq_pc);

    fetch_packet_expand u_expand (
        .i_pkt        (w_pkt),
        .o_slot_valid (w_slot_valid),
        .o_slot       (w_slot),
        .o_nenq       (w_nenq)
    );

    // Ready depends on registered occupancy only, so no dequeue credit and no path from flush.
    assign w_enq_ready = (r_count <= CNT_W'(NUM_ENTRIES - FETCH_WIDTH));
    assign w_enq_fire  = io.enq_valid && w_enq_ready && !io.flush;
    assign w_deq_fire  = io.deq_ready && !io.flush;
    assign w_ndeq      = (r_count > CNT_W'(DEQ_WIDTH)) ? CNT_W'(DEQ_WIDTH) : r_count;

    // Live slot k lands at tail + (k - off) so kept instructions stay contiguous.
    always_comb begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            w_wr_idx[k] = r_tail + PTR_W'(k) - PTR_W'(w_off);
        end
    end

    // Entry storage write; contents are not reset, pointers alone define validity.
    always_ff @(posedge clock) begin
        if (w_enq_fire) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (w_slot_valid[k]) begin
                    r_mem[w_wr_idx[k]] <= w_slot[k];
                end
            end
        end
    end

    // Pointer and occupancy update; reset and flush both empty the queue.
    always_ff @(posedge clock) begin
        if (reset || io.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_deq_fire) begin
                r_head <= r_head + PTR_W'(w_ndeq);
            end
            if (w_enq_fire) begin
                r_tail <= r_tail + PTR_W'(w_nenq);
            end
            r_count <= r_count
                     - (w_deq_fire ? w_ndeq : '0)
                     + (w_enq_fire ? CNT_W'(w_nenq) : '0);
        end
    end

    // Decode lanes read straight from the head of the queue; flush masks them in its own cycle.
    always_comb begin
        for (int j = 0; j < DEQ_WIDTH; j++) begin
            io.deq_valid[j]                         = (r_count > CNT_W'(j)) && !io.flush;
            io.deq_inst[j*INST_BITS +: INST_BITS]   = r_mem[r_head + PTR_W'(j)].inst;
            io.deq_pc[j*VADDR_BITS +: VADDR_BITS]   = r_mem[r_head + PTR_W'(j)].pc;
        end
    end

    assign io.enq_ready = w_enq_ready;
    assign io.count     = r_count;

endmodule

// File: tb/tb_fetch_buffer.sv
// Testbench for fetch_buffer: directed scenarios plus a randomized run against a queue model.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int NE = 16;
    localparam int DW = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_buffer_if #(.NUM_ENTRIES(NE), .DEQ_WIDTH(DW)) bus ();

    fetch_buffer #(.NUM_ENTRIES(NE), .DEQ_WIDTH(DW)) dut (
        .clock (clk),
        .reset (rst),
        .io    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the buffer is just an ordered list of (inst, pc) pairs.
    logic [31:0] mq_inst [$];
    logic [38:0] mq_pc   [$];

    task automatic model_step();
        int  n;
        int  off;
        bit  rdy;
        rdy = (NE - mq_inst.size()) >= FETCH_WIDTH;
        if (rst || bus.flush) begin
            mq_inst.delete();
            mq_pc.delete();
            return;
        end
        if (bus.deq_ready) begin
            n = (mq_inst.size() < DW) ? mq_inst.size() : DW;
            repeat (n) begin
                void'(mq_inst.pop_front());
                void'(mq_pc.pop_front());
            end
        end
        if (bus.enq_valid && rdy) begin
            off = int'(bus.enq_pc[3:2]);
            for (int k = off; k < FETCH_WIDTH; k++) begin
                mq_inst.push_back(bus.enq_data[32*k +: 32]);
                mq_pc.push_back({bus.enq_pc[38:4], 2'(k), 2'b00});
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.enq_valid = 1'b0;
        bus.enq_data  = '0;
        bus.enq_pc    = '0;
        bus.deq_ready = 1'b0;
        bus.flush     = 1'b0;
    endtask

    function automatic logic [127:0] mkpkt(input logic [31:0] base);
        logic [127:0] d;
        for (int k = 0; k < 4; k++) d[32*k +: 32] = base + 32'(k);
        return d;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        checks++; if (bus.deq_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want 00", bus.deq_valid); end
        checks++; if (bus.enq_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.enq_ready); end
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    endtask

    task automatic test_aligned();
        bus.enq_valid = 1'b1;
        bus.enq_pc    = 39'h1000;
        bus.enq_data  = mkpkt(32'hA0);
        cycle();
        idle();
        #1;
        checks++; if (bus.count !== 5'd4) begin errors++; $display("FAIL aligned_count got %0d want 4", bus.count); end
        checks++; if (bus.deq_valid !== 2'b11) begin errors++; $display("FAIL aligned_valid got %b want 11", bus.deq_valid); end
        checks++; if (bus.deq_inst !== 64'h000000A1_000000A0) begin errors++; $display("FAIL aligned_inst got %h want 000000a1000000a0", bus.deq_inst); end
        checks++; if (bus.deq_pc[38:0] !== 39'h1000 || bus.deq_pc[77:39] !== 39'h1004) begin errors++; $display("FAIL aligned_pc got %h/%h want 1000/1004", bus.deq_pc[38:0], bus.deq_pc[77:39]); end
        bus.deq_ready = 1'b1;
        cycle();
        bus.deq_ready = 1'b0;
        #1;
        checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL aligned_deq_count got %0d want 2", bus.count); end
        checks++; if (bus.deq_inst !== 64'h000000A3_000000A2) begin errors++; $display("FAIL aligned_deq_inst got %h want 000000a3000000a2", bus.deq_inst); end
        checks++; if (bus.deq_pc[38:0] !== 39'h1008 || bus.deq_pc[77:39] !== 39'h100C) begin errors++; $display("FAIL aligned_deq_pc got %h/%h want 1008/100c", bus.deq_pc[38:0], bus.deq_pc[77:39]); end
        bus.deq_ready = 1'b1;
        cycle();
        bus.deq_ready = 1'b0;
        #1;
        checks++; if (bus.count !== 5'd0 || bus.deq_valid !== 2'b00) begin errors++; $display("FAIL aligned_drain got count %0d valid %b want 0/00", bus.count, bus.deq_valid); end
    endtask

    task automatic test_misaligned();
        bus.enq_valid = 1'b1;
        bus.enq_pc    = 39'h200C;
        bus.enq_data  = mkpkt(32'hB0);
        cycle();
        idle();
        #1;
        checks++; if (bus.deq_valid !== 2'b01) begin errors++; $display("FAIL misalign_valid got %b want 01", bus.deq_valid); end
        checks++; if (bus.deq_inst[31:0] !== 32'hB3 || bus.deq_pc[38:0] !== 39'h200C) begin errors++; $display("FAIL misalign_lane0 got %h@%h want b3@200c", bus.deq_inst[31:0], bus.deq_pc[38:0]); end
        checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL misalign_count got %0d want 1", bus.count); end
        bus.deq_ready = 1'b1;
        cycle();
        idle();
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            bus.enq_valid = 1'b1;
            bus.enq_pc    = 39'h3000 + 39'(16 * i);
            bus.enq_data  = mkpkt(32'hD000_0000 + 32'(16 * i));
            #1;
            checks++; if (bus.enq_ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready[%0d] got %b want 1", i, bus.enq_ready); end
            cycle();
        end
        idle();
        #1;
        checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL full_count got %0d want 16", bus.count); end
        checks++; if (bus.enq_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", bus.enq_ready); end
        bus.enq_valid = 1'b1;
        bus.enq_pc    = 39'h4000;
        bus.enq_data  = mkpkt(32'hE000_0000);
        cycle();
        idle();
        #1;
        checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL full_blocked_count got %0d want 16", bus.count); end
        bus.deq_ready = 1'b1;
        cycle();
        bus.deq_ready = 1'b0;
        #1;
        checks++; if (bus.count !== 5'd14 || bus.enq_ready !== 1'b0) begin errors++; $display("FAIL full_deq1 got count %0d ready %b want 14/0", bus.count, bus.enq_ready); end
        checks++; if (bus.deq_inst[31:0] !== 32'hD000_0002 || bus.deq_pc[38:0] !== 39'h3008) begin errors++; $display("FAIL full_deq1_lane0 got %h@%h want d0000002@3008", bus.deq_inst[31:0], bus.deq_pc[38:0]); end
        bus.deq_ready = 1'b1;
        cycle();
        bus.deq_ready = 1'b0;
        #1;
        checks++; if (bus.count !== 5'd12 || bus.enq_ready !== 1'b1) begin errors++; $display("FAIL full_deq2 got count %0d ready %b want 12/1", bus.count, bus.enq_ready); end
        bus.flush = 1'b1;
        cycle();
        idle();
        #1;
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL full_flush_count got %0d want 0", bus.count); end
    endtask

    task automatic test_random();
        logic [38:0] pc;
        logic [1:0]  exp_valid;
        int          n;
        for (int c = 0; c < 40; c++) begin
            pc = 39'({$urandom(), $urandom()});
            pc[1:0] = 2'b00;
            bus.enq_valid = ($urandom_range(0, 3) != 0);
            bus.enq_pc    = pc;
            bus.enq_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.deq_ready = 1'b1;
            #1;
            n = (mq_inst.size() < DW) ? mq_inst.size() : DW;
            exp_valid = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
            checks++; if (bus.deq_valid !== exp_valid) begin errors++; $display("FAIL rand_valid c%0d got %b want %b", c, bus.deq_valid, exp_valid); end
            for (int j = 0; j < n; j++) begin
                checks++;
                if (bus.deq_inst[32*j +: 32] !== mq_inst[j] || bus.deq_pc[39*j +: 39] !== mq_pc[j]) begin
                    errors++;
                    $display("FAIL rand_lane%0d c%0d got %h@%h want %h@%h", j, c, bus.deq_inst[32*j +: 32], bus.deq_pc[39*j +: 39], mq_inst[j], mq_pc[j]);
                end
            end
            checks++; if (int'(bus.count) !== mq_inst.size() || bus.count > 5'd16) begin errors++; $display("FAIL rand_count c%0d got %0d want %0d", c, bus.count, mq_inst.size()); end
            checks++; if (bus.enq_ready !== ((NE - mq_inst.size()) >= FETCH_WIDTH)) begin errors++; $display("FAIL rand_ready c%0d got %b want %b", c, bus.enq_ready, (NE - mq_inst.size()) >= FETCH_WIDTH); end
            cycle();
        end
        idle();
        bus.flush = 1'b1;
        cycle();
        idle();
    endtask

    task automatic test_flush();
        bus.enq_valid = 1'b1;
        bus.enq_pc    = 39'h6000;
        bus.enq_data  = mkpkt(32'hF0);
        cycle();
        bus.enq_pc    = 39'h6018;
        bus.enq_data  = mkpkt(32'hF8);
        cycle();
        idle();
        #1;
        checks++; if (bus.count !== 5'd6) begin errors++; $display("FAIL flush_pre_count got %0d want 6", bus.count); end
        bus.flush     = 1'b1;
        bus.enq_valid = 1'b1;
        bus.enq_pc    = 39'h7000;
        bus.enq_data  = mkpkt(32'h70);
        bus.deq_ready = 1'b1;
        #1;
        checks++; if (bus.deq_valid !== 2'b00) begin errors++; $display("FAIL flush_cycle_valid got %b want 00", bus.deq_valid); end
        cycle();
        idle();
        #1;
        checks++; if (bus.count !== 5'd0 || bus.deq_valid !== 2'b00) begin errors++; $display("FAIL flush_after got count %0d valid %b want 0/00", bus.count, bus.deq_valid); end
        cycle();
        checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL flush_dropped got %0d want 0", bus.count); end
        bus.enq_valid = 1'b1;
        bus.enq_pc    = 39'h8004;
        bus.enq_data  = mkpkt(32'h80);
        cycle();
        idle();
        #1;
        checks++; if (bus.count !== 5'd3 || bus.deq_inst[31:0] !== 32'h81 || bus.deq_pc[38:0] !== 39'h8004) begin errors++; $display("FAIL flush_refill got count %0d %h@%h want 3 81@8004", bus.count, bus.deq_inst[31:0], bus.deq_pc[38:0]); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        checks++; if (bus.count !== 5'd0 || bus.deq_valid !== 2'b00 || bus.enq_ready !== 1'b1) begin errors++; $display("FAIL midreset got count %0d valid %b ready %b want 0/00/1", bus.count, bus.deq_valid, bus.enq_ready); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        test_reset();
        test_aligned();
        test_misaligned();
        test_full();
        test_random();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
